// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int TMO_W          = 8;

endpackage

// File: rtl/fetch_unit_word_assembler.sv
// Collects four memory bytes into a shadow word and copies it to the visible
// instruction word on commit.
module fetch_unit_word_assembler
    import fetch_unit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_n_rst,
    input  logic              i_wr_en,
    input  logic [1:0]        i_idx,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_commit,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W-1:0] r_shadow;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_shadow_nxt;

    // Merge the incoming byte so a commit on the last byte sees the full word.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (i_wr_en) begin
            w_shadow_nxt[{i_idx, 3'b000} +: BYTE_W] = i_data;
        end else begin
            w_shadow_nxt = r_shadow;
        end
    end

    // Shadow and committed word registers.
    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_shadow <= '0;
            r_word   <= '0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (i_commit) begin
                r_word <= w_shadow_nxt;
            end else begin
                r_word <= r_word;
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 32-bit word LSB-first from
// byte-wide program memory with wait states, alignment and timeout faults.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          ADDR_W         = 24,
    parameter int unsigned RESET_PC       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              N_RST,
    input  logic              N_BOOTED,
    input  logic              FETCH,
    input  logic              PC_LOAD,
    input  logic [31:0]       BUS,
    output logic [31:0]       WORD,
    output logic [ADDR_W-1:0] PC,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAULT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_N_RD,
    input  logic [7:0]        MEM_DATA,
    input  logic              MEM_READY
);

    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(BYTES_PER_WORD);
    localparam logic [TMO_W-1:0]  TMO_LIM = TMO_W'(TIMEOUT_CYCLES);

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [1:0]        r_idx, w_idx_nxt, w_idx_inc;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt, w_tmo_inc;
    logic              r_fault, w_fault_nxt;
    logic              w_wr_en;
    logic              w_commit;
    logic [31:0]       w_word;
    logic              w_unused_bus;

    assign w_idx_inc    = r_idx + 2'd1;
    assign w_tmo_inc    = r_tmo + 8'd1;
    assign w_unused_bus = ^BUS;

    // Next-state, datapath updates and assembler strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mem_addr_nxt = r_mem_addr;
        w_idx_nxt      = r_idx;
        w_tmo_nxt      = r_tmo;
        w_fault_nxt    = r_fault;
        w_wr_en        = 1'b0;
        w_commit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (N_BOOTED) begin
                    w_state_nxt = ST_IDLE;
                end else if (PC_LOAD) begin
                    w_pc_nxt    = BUS[ADDR_W-1:0];
                    w_fault_nxt = 1'b0;
                end else if (FETCH && !r_fault) begin
                    if (r_pc[1:0] != 2'd0) begin
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_idx_nxt      = 2'd0;
                        w_tmo_nxt      = 8'd0;
                        w_mem_addr_nxt = r_pc;
                        w_state_nxt    = ST_READ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (MEM_READY) begin
                    w_wr_en   = 1'b1;
                    w_tmo_nxt = 8'd0;
                    if (r_idx == 2'd3) begin
                        w_commit    = 1'b1;
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt      = w_idx_inc;
                        w_mem_addr_nxt = r_pc + ADDR_W'(w_idx_inc);
                    end
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                    // The partially filled shadow is simply never committed.
                    if (w_tmo_inc == TMO_LIM) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, PC, counters, fault flag and memory address registers.
    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            r_state    <= ST_IDLE;
            r_pc       <= PC_RST;
            r_mem_addr <= '0;
            r_idx      <= 2'd0;
            r_tmo      <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_idx      <= w_idx_nxt;
            r_tmo      <= w_tmo_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    fetch_unit_word_assembler u_asm (
        .i_clk    (CLK),
        .i_n_rst  (N_RST),
        .i_wr_en  (w_wr_en),
        .i_idx    (r_idx),
        .i_data   (MEM_DATA),
        .i_commit (w_commit),
        .o_word   (w_word)
    );

    assign WORD     = w_word;
    assign PC       = r_pc;
    assign BUSY     = (r_state == ST_READ);
    assign DONE     = (r_state == ST_DONE);
    assign FAULT    = r_fault;
    assign MEM_ADDR = r_mem_addr;
    assign MEM_N_RD = (r_state != ST_READ);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: normal fetch, wait states,
// alignment fault, timeout, boot hold, mid-fetch reset and PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        n_rst, n_booted, fetch, pc_load, mem_ready;
    logic [31:0] bus;
    logic [31:0] word;
    logic [23:0] pc, mem_addr;
    logic        busy, done, fault, mem_n_rd;
    logic [7:0]  mem_data;

    logic        fetch2, pc_load2, mem_ready2;
    logic [31:0] word2;
    logic [23:0] pc2, mem_addr2;
    logic        busy2, done2, fault2, mem_n_rd2;
    logic [7:0]  mem_data2;

    int n_checks = 0;
    int n_errors = 0;
    int done_k;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000000: mem_byte = 8'h11;
            24'h000001: mem_byte = 8'h22;
            24'h000002: mem_byte = 8'h33;
            24'h000003: mem_byte = 8'h44;
            24'h000100: mem_byte = 8'hA1;
            24'h000101: mem_byte = 8'hB2;
            24'h000102: mem_byte = 8'hC3;
            24'h000103: mem_byte = 8'hD4;
            24'hFFFFFC: mem_byte = 8'h5A;
            24'hFFFFFD: mem_byte = 8'h6B;
            24'hFFFFFE: mem_byte = 8'h7C;
            24'hFFFFFF: mem_byte = 8'h8D;
            default:    mem_byte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    assign mem_data  = mem_byte(mem_addr);
    assign mem_data2 = mem_byte(mem_addr2);

    fetch_unit dut (
        .CLK(clk), .N_RST(n_rst), .N_BOOTED(n_booted), .FETCH(fetch),
        .PC_LOAD(pc_load), .BUS(bus), .WORD(word), .PC(pc), .BUSY(busy),
        .DONE(done), .FAULT(fault), .MEM_ADDR(mem_addr), .MEM_N_RD(mem_n_rd),
        .MEM_DATA(mem_data), .MEM_READY(mem_ready)
    );

    fetch_unit #(.TIMEOUT_CYCLES(4)) dut_tmo (
        .CLK(clk), .N_RST(n_rst), .N_BOOTED(n_booted), .FETCH(fetch2),
        .PC_LOAD(pc_load2), .BUS(bus), .WORD(word2), .PC(pc2), .BUSY(busy2),
        .DONE(done2), .FAULT(fault2), .MEM_ADDR(mem_addr2), .MEM_N_RD(mem_n_rd2),
        .MEM_DATA(mem_data2), .MEM_READY(mem_ready2)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_at(input int k, input int s, input int n);
        rdy_at = !(k >= s && k < s + n);
    endfunction

    // Issue FETCH and count cycles until DONE; ready low for cycles s..s+n-1.
    task automatic run_fetch(input int s, input int n, output int dk);
        dk = -1;
        fetch = 1'b1;
        mem_ready = rdy_at(1, s, n);
        for (int k = 1; k <= 40; k++) begin
            tick();
            fetch = 1'b0;
            if (done) begin
                dk = k;
                break;
            end
            mem_ready = rdy_at(k + 1, s, n);
        end
        mem_ready = 1'b1;
    endtask

    task automatic load_pc(input logic [31:0] v);
        bus = v;
        pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; n_booted = 1'b0; fetch = 1'b0; pc_load = 1'b0;
        mem_ready = 1'b1; bus = 32'h0;
        fetch2 = 1'b0; pc_load2 = 1'b0; mem_ready2 = 1'b1;
        tick();
        tick();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_nrd", {31'd0, mem_n_rd}, 32'd1);
        check_eq("rst_addr", {8'd0, mem_addr}, 32'd0);
        check_eq("rst_pc", {8'd0, pc}, 32'd0);
        check_eq("rst_word", word, 32'd0);
        n_rst = 1'b1;
        tick();

        // Basic fetch with memory always ready.
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check_eq("f1_busy", {31'd0, busy}, 32'd1);
        check_eq("f1_nrd", {31'd0, mem_n_rd}, 32'd0);
        check_eq("f1_addr0", {8'd0, mem_addr}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_eq("f1_addr", {8'd0, mem_addr}, i);
        end
        tick();
        check_eq("f1_done", {31'd0, done}, 32'd1);
        check_eq("f1_busy_d", {31'd0, busy}, 32'd0);
        check_eq("f1_word", word, 32'h44332211);
        check_eq("f1_pc", {8'd0, pc}, 32'd4);
        tick();
        check_eq("f1_done_pulse", {31'd0, done}, 32'd0);

        // Three wait states on byte 2.
        load_pc(32'h0);
        check_eq("ws_pc", {8'd0, pc}, 32'd0);
        run_fetch(3, 3, done_k);
        check_eq("ws_latency", done_k, 32'd8);
        check_eq("ws_word", word, 32'h44332211);
        check_eq("ws_fault", {31'd0, fault}, 32'd0);
        tick();

        // Misaligned PC faults without touching memory.
        load_pc(32'h000102);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check_eq("al_fault", {31'd0, fault}, 32'd1);
        check_eq("al_nrd", {31'd0, mem_n_rd}, 32'd1);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check_eq("al_ign_busy", {31'd0, busy}, 32'd0);
        check_eq("al_ign_nrd", {31'd0, mem_n_rd}, 32'd1);
        check_eq("al_ign_pc", {8'd0, pc}, 32'h102);
        load_pc(32'h100);
        check_eq("al_clr", {31'd0, fault}, 32'd0);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("al_addr", {8'd0, mem_addr}, 32'h100 + i);
            tick();
        end
        check_eq("al_done", {31'd0, done}, 32'd1);
        check_eq("al_word", word, 32'hD4C3B2A1);
        check_eq("al_pc", {8'd0, pc}, 32'h104);
        tick();

        // Timeout on the TIMEOUT_CYCLES=4 instance after one good fetch.
        fetch2 = 1'b1;
        tick();
        fetch2 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("to_pre_word", word2, 32'h44332211);
        tick();
        mem_ready2 = 1'b0;
        fetch2 = 1'b1;
        tick();
        fetch2 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("to_busy4", {31'd0, busy2}, 32'd1);
        check_eq("to_nofault4", {31'd0, fault2}, 32'd0);
        tick();
        check_eq("to_fault", {31'd0, fault2}, 32'd1);
        check_eq("to_idle", {31'd0, busy2}, 32'd0);
        check_eq("to_nrd", {31'd0, mem_n_rd2}, 32'd1);
        check_eq("to_pc", {8'd0, pc2}, 32'd4);
        check_eq("to_word", word2, 32'h44332211);
        mem_ready2 = 1'b1;

        // Boot hold: FETCH ignored while N_BOOTED is high.
        n_booted = 1'b1;
        fetch = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("boot_busy", {31'd0, busy}, 32'd0);
            check_eq("boot_nrd", {31'd0, mem_n_rd}, 32'd1);
        end
        n_booted = 1'b0;
        tick();
        fetch = 1'b0;
        check_eq("boot_start", {31'd0, busy}, 32'd1);
        check_eq("boot_addr", {8'd0, mem_addr}, 32'h104);
        for (int i = 0; i < 4; i++) tick();
        check_eq("boot_done", {31'd0, done}, 32'd1);
        check_eq("boot_word", word, 32'hA2A3A0A1);
        check_eq("boot_pc", {8'd0, pc}, 32'h108);
        tick();

        // Reset in the middle of a fetch.
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        tick();
        check_eq("mr_idx1", {8'd0, mem_addr}, 32'h109);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check_eq("mr_busy", {31'd0, busy}, 32'd0);
        check_eq("mr_pc", {8'd0, pc}, 32'd0);
        check_eq("mr_word", word, 32'd0);
        check_eq("mr_nrd", {31'd0, mem_n_rd}, 32'd1);
        check_eq("mr_addr", {8'd0, mem_addr}, 32'd0);
        tick();

        // Fetch from the top word of the address space wraps PC to zero.
        load_pc(32'h00FFFFFC);
        run_fetch(0, 0, done_k);
        check_eq("wr_latency", done_k, 32'd5);
        check_eq("wr_word", word, 32'h8D7C6B5A);
        check_eq("wr_pc", {8'd0, pc}, 32'd0);
        check_eq("wr_addr_hold", {8'd0, mem_addr}, 32'hFFFFFF);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the KPU opword register.
- Holds the program counter and reads a 32-bit instruction word from byte-wide program memory, least significant byte first.
- Presents the assembled word for the top level to drive onto the bus through a buffer32 when control logic latches the opword.
- Supports wait-state memory via a ready handshake, PC load from the bus, alignment and timeout faults, and a hold while bootstrapping.

Parameters:
ADDR_W, 24, width of PC and memory byte address
RESET_PC, 0, PC value after reset (must be 4-byte aligned)
TIMEOUT_CYCLES, 255, max consecutive not-ready cycles per byte before fault (1..255)

Ports:
CLK  in  1  system clock, all state on rising edge
N_RST  in  1  synchronous active-low reset
N_BOOTED  in  1  1 = bootstrap in progress; fetch held off
FETCH  in  1  request fetch at PC; sampled only in IDLE
PC_LOAD  in  1  load PC from BUS[ADDR_W-1:0]; sampled only in IDLE
BUS  in  32  KPU bus value
WORD  out  32  last completed instruction word
PC  out  ADDR_W  current program counter
BUSY  out  1  fetch in progress
DONE  out  1  one-cycle pulse, WORD updated this cycle
FAULT  out  1  sticky error flag
MEM_ADDR  out  ADDR_W  byte address to program memory
MEM_N_RD  out  1  active-low memory read strobe
MEM_DATA  in  8  memory read data
MEM_READY  in  1  MEM_DATA valid this cycle

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous and active-low on N_RST.
- Reset values (N_RST low at an edge, from any state, including mid-fetch):
  - state IDLE, PC = RESET_PC, WORD = 0, byte index = 0, timeout counter = 0, shadow word = 0.
  - BUSY = 0, DONE = 0, FAULT = 0, MEM_N_RD = 1, MEM_ADDR = 0.
- State IDLE: MEM_N_RD = 1, BUSY = 0. Priority at each edge:
  1. N_BOOTED = 1: stay IDLE, ignore FETCH and PC_LOAD.
  2. PC_LOAD = 1: PC <= BUS[ADDR_W-1:0], FAULT <= 0, FETCH ignored this cycle.
  3. FETCH = 1 and FAULT = 1: ignored.
  4. FETCH = 1 and PC[1:0] != 0: FAULT <= 1, no memory access, stay IDLE.
  5. FETCH = 1 otherwise: byte index <= 0, timeout counter <= 0, go to READ.
- State READ: BUSY = 1, MEM_N_RD = 0, MEM_ADDR = PC + byte index.
  - MEM_READY = 1: shadow[8*idx+7 : 8*idx] <= MEM_DATA and timeout counter <= 0.
    - idx < 3: idx <= idx + 1, stay in READ.
    - idx = 3: go to DONE.
  - MEM_READY = 0: timeout counter increments.
    - Counter reaches TIMEOUT_CYCLES: FAULT <= 1, go to IDLE; PC and WORD unchanged, partial shadow discarded.
- State DONE (one cycle): DONE = 1, BUSY = 0, MEM_N_RD = 1.
  - WORD and PC update at the edge entering DONE: WORD <= shadow, PC <= PC + 4 mod 2^ADDR_W.
  - Next state IDLE; FETCH is not sampled in DONE.
- Latency: FETCH sampled at edge t with MEM_READY constantly 1 gives READ during cycles t+1..t+4 and DONE high in cycle t+5. Each not-ready cycle adds one cycle.
- FETCH and PC_LOAD asserted outside IDLE are ignored; a FORMAL assertion checks that PC_LOAD is never high while BUSY = 1.
- Wrap-around: PC = 2^ADDR_W - 4 fetches bytes at the top 4 addresses, then PC becomes 0. Aligned fetches never wrap within a word.
- MEM_ADDR holds its last value while MEM_N_RD = 1.

Decomposition:
- Shared constants in common.v:
  - fetch state encodings (IDLE, READ, DONE as `define localparams).
  - instruction word width 32 and bytes per word 4.
- One natural sub-module, word_assembler:
  - 4x8-bit shadow register with byte-indexed write enable.
  - commit strobe copying the shadow into WORD.
- FSM, PC and timeout counter stay in fetch_unit.

Test Plan:
- Reset, then FETCH with PC = 0, MEM_READY = 1, memory bytes 0x11, 0x22, 0x33, 0x44 at 0..3 -> MEM_ADDR steps 0, 1, 2, 3; DONE in cycle t+5; WORD = 0x44332211; PC = 4.
- MEM_READY low for 3 cycles on byte 2 -> DONE in cycle t+8, same WORD, FAULT = 0.
- PC_LOAD with BUS = 0x000102 then FETCH -> FAULT = 1 and MEM_N_RD stays 1. Later FETCH is ignored. PC_LOAD with BUS = 0x100 clears FAULT, and the next FETCH reads addresses 0x100..0x103.
- TIMEOUT_CYCLES = 4 with MEM_READY held 0 -> FAULT after 4 READ cycles; PC and WORD unchanged; state IDLE.
- N_BOOTED = 1 with FETCH = 1 for 10 cycles -> BUSY = 0 and MEM_N_RD = 1 throughout. Dropping N_BOOTED to 0 starts the fetch on the next edge.
- N_RST low during READ byte 1 -> next cycle IDLE, PC = RESET_PC, WORD = 0, MEM_N_RD = 1. Separately, PC = 0xFFFFFC with ADDR_W = 24 and a fetch -> PC = 0.
